// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if
//   Groups the execute-stage handshake and data signals into one bundle.
//   Upstream side : in_valid, in_ready, alu_control, op_a, op_b, rd_in, reg_write_in
//   Downstream side: out_valid, out_ready, result, zero, illegal, rd_out, reg_write_out
//   Debug         : illegal_cnt (saturating count of accepted illegal ops)
//   Modports:
//     slave  - the execute stage itself
//     master - the environment driving ops in and taking results out
interface alu_exec_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [4:0]       rd_in;
    logic             reg_write_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             illegal;
    logic [4:0]       rd_out;
    logic             reg_write_out;
    logic [CNT_W-1:0] illegal_cnt;

    modport slave (
        input  in_valid, alu_control, op_a, op_b, rd_in, reg_write_in, out_ready,
        output in_ready, out_valid, result, zero, illegal, rd_out, reg_write_out,
               illegal_cnt
    );

    modport master (
        output in_valid, alu_control, op_a, op_b, rd_in, reg_write_in, out_ready,
        input  in_ready, out_valid, result, zero, illegal, rd_out, reg_write_out,
               illegal_cnt
    );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage behind the ALU control decoder. Computes ADD/SUB/AND/OR on
//   the incoming operands, registers the result behind a valid/ready handshake
//   with a one-entry skid buffer, flags illegal control codes and keeps a
//   saturating count of them.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - alu_exec_stage_if.slave (handshakes, operands, results, debug count)
module alu_exec_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_exec_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            illegal;
        logic [4:0]      rd;
        logic            reg_write;
    } payload_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    payload_t         r_out;
    payload_t         r_skid;
    payload_t         w_new;
    logic [XLEN-1:0]  w_res;
    logic             w_illegal;
    logic             w_accept;
    logic             w_transfer;
    logic             w_load_out_new;
    logic             w_load_out_skid;
    logic             w_load_skid;
    logic [CNT_W-1:0] r_illegal_cnt;

    // Handshake qualifiers come straight from the state register, so in_ready
    // never depends combinationally on out_ready.
    assign w_accept   = bus.in_valid & (r_state != S_FULL);
    assign w_transfer = (r_state != S_EMPTY) & bus.out_ready;

    // ALU datapath
    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (bus.alu_control)
            4'b0010: w_res = bus.op_a + bus.op_b;
            4'b0110: w_res = bus.op_a - bus.op_b;
            4'b0000: w_res = bus.op_a & bus.op_b;
            4'b0001: w_res = bus.op_a | bus.op_b;
            default: w_illegal = 1'b1;
        endcase
        w_new.result    = w_res;
        w_new.zero      = (w_res == '0);
        w_new.illegal   = w_illegal;
        w_new.rd        = bus.rd_in;
        w_new.reg_write = bus.reg_write_in & ~w_illegal;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_next_state = S_ONE;
            S_ONE: begin
                if (w_accept && !w_transfer)      w_next_state = S_FULL;
                else if (!w_accept && w_transfer) w_next_state = S_EMPTY;
            end
            S_FULL:  if (w_transfer) w_next_state = S_ONE;
            default: w_next_state = S_EMPTY;
        endcase
    end

    // FSM: outputs and register load strobes
    always_comb begin
        bus.in_ready    = (r_state != S_FULL);
        bus.out_valid   = (r_state != S_EMPTY);
        w_load_out_new  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            S_EMPTY: w_load_out_new = w_accept;
            S_ONE: begin
                w_load_out_new = w_accept & w_transfer;
                w_load_skid    = w_accept & ~w_transfer;
            end
            S_FULL:  w_load_out_skid = w_transfer;
            default: ;
        endcase
    end

    // Output register and skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_new) begin
                r_out <= w_new;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_new;
            end
        end
    end

    // Saturating illegal-op counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && w_illegal && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign bus.result        = r_out.result;
    assign bus.zero          = r_out.zero;
    assign bus.illegal       = r_out.illegal;
    assign bus.rd_out        = r_out.rd;
    assign bus.reg_write_out = r_out.reg_write;
    assign bus.illegal_cnt   = r_illegal_cnt;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    logic clk;
    logic rst_n;

    alu_exec_stage_if #(.XLEN(32), .CNT_W(8)) bus ();

    alu_exec_stage #(.XLEN(32), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    bit   rand_rdy = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] code, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd,
                                   input logic rw);
        exp_t e;
        e.ill = 1'b0;
        case (code)
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            default: begin e.res = 32'h0; e.ill = 1'b1; end
        endcase
        e.z  = (e.res == 32'h0);
        e.rd = rd;
        e.rw = rw & ~e.ill;
        return e;
    endfunction

    // One clock: called at a negedge, observes handshakes, advances to next negedge.
    task automatic tick();
        exp_t e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", {32'd0, bus.result}, {32'd0, e.res});
                chk("zero", {63'd0, bus.zero}, {63'd0, e.z});
                chk("illegal", {63'd0, bus.illegal}, {63'd0, e.ill});
                chk("rd_out", {59'd0, bus.rd_out}, {59'd0, e.rd});
                chk("reg_write_out", {63'd0, bus.reg_write_out}, {63'd0, e.rw});
            end
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            e = model(bus.alu_control, bus.op_a, bus.op_b, bus.rd_in, bus.reg_write_in);
            exp_q.push_back(e);
            if (e.ill && exp_cnt < 255) exp_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("illegal_cnt", {56'd0, bus.illegal_cnt}, 64'(exp_cnt));
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw);
        bit done = 0;
        bus.alu_control  = code;
        bus.op_a         = a;
        bus.op_b         = b;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
        bus.in_valid     = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready === 1'b1) done = 1;
            tick();
        end
        if (!done) chk("send_timeout", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_rdy      = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && bus.out_valid === 1'b0) break;
            tick();
        end
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.alu_control  = 4'b0000;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.rd_in        = '0;
        bus.reg_write_in = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_zero", {63'd0, bus.zero}, 64'd0);
        chk("rst_illegal", {63'd0, bus.illegal}, 64'd0);
        chk("rst_rd_out", {59'd0, bus.rd_out}, 64'd0);
        chk("rst_reg_write", {63'd0, bus.reg_write_out}, 64'd0);
        chk("rst_cnt", {56'd0, bus.illegal_cnt}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD with one-cycle latency
        bus.out_ready = 1'b1;
        send(4'b0010, 32'd5, 32'd7, 5'd3, 1'b1);
        chk("add_latency", {63'd0, bus.out_valid}, 64'd1);
        chk("add_value", {32'd0, bus.result}, 64'd12);
        drain();

        // SUB zero and wraparound, logic ops
        send(4'b0110, 32'd9, 32'd9, 5'd4, 1'b1);
        send(4'b0110, 32'd0, 32'd1, 5'd5, 1'b1);
        send(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd6, 1'b1);
        send(4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7, 1'b0);
        drain();

        // Back-pressure: two held, third refused until release
        bus.out_ready = 1'b0;
        send(4'b0010, 32'd100, 32'd1, 5'd8, 1'b1);
        send(4'b0110, 32'd100, 32'd1, 5'd9, 1'b1);
        chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_held", 64'(exp_q.size()), 64'd2);
        bus.alu_control  = 4'b0001;
        bus.op_a         = 32'h0000_00A0;
        bus.op_b         = 32'h0000_000B;
        bus.rd_in        = 5'd10;
        bus.reg_write_in = 1'b1;
        bus.in_valid     = 1'b1;
        tick();
        tick();
        chk("bp_still_full", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_hold_result", {32'd0, bus.result}, {32'd0, exp_q[0].res});
        chk("bp_hold_rd", {59'd0, bus.rd_out}, {59'd0, exp_q[0].rd});
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && bus.in_valid; i++) begin
            if (bus.in_ready === 1'b1) begin
                tick();
                bus.in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        drain();

        // Single illegal op
        send(4'b1111, 32'd1, 32'd2, 5'd11, 1'b1);
        chk("ill_flag", {63'd0, bus.illegal}, 64'd1);
        chk("ill_reg_write", {63'd0, bus.reg_write_out}, 64'd0);
        drain();
        chk("ill_cnt_one", {56'd0, bus.illegal_cnt}, 64'd1);

        // Random mix under random back-pressure
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            send(c, $urandom, (i % 5 == 0) ? 32'h0 : $urandom, 5'($urandom), 1'($urandom));
        end
        drain();

        // Saturation: 300 illegal ops
        for (int i = 0; i < 300; i++) begin
            send(4'(3 + (i % 3)), $urandom, $urandom, 5'(i), 1'b1);
        end
        drain();
        chk("ill_cnt_sat", {56'd0, bus.illegal_cnt}, 64'd255);

        // Reset while FULL
        bus.out_ready = 1'b0;
        send(4'b0010, 32'd1, 32'd1, 5'd12, 1'b1);
        send(4'b0010, 32'd2, 32'd2, 5'd13, 1'b1);
        chk("pre_rst_full", {63'd0, bus.in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("mid_rst_cnt", {56'd0, bus.illegal_cnt}, 64'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("post_rst_result", {32'd0, bus.result}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
